// File: rtl/nice_icb_mem_slave.sv
// ICB memory slave: 2^AW x 32-bit word memory with byte/halfword/word access,
// error checking and a 2-deep in-order response FIFO.
module nice_icb_mem_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          AW        = 10
) (
   input  logic        nice_clk,
   input  logic        nice_rst_n,
   input  logic        nice_icb_cmd_valid,
   output logic        nice_icb_cmd_ready,
   input  logic [31:0] nice_icb_cmd_addr,
   input  logic        nice_icb_cmd_read,
   input  logic [31:0] nice_icb_cmd_wdata,
   input  logic [1:0]  nice_icb_cmd_size,
   output logic        nice_icb_rsp_valid,
   input  logic        nice_icb_rsp_ready,
   output logic [31:0] nice_icb_rsp_rdata,
   output logic        nice_icb_rsp_err
);

   localparam int DEPTH = 1 << AW;

   logic [31:0]   mem [DEPTH];
   logic [1:0]    count;
   logic [31:0]   head_rdata;
   logic [31:0]   tail_rdata;
   logic          head_err;
   logic          tail_err;

   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          range_err;
   logic          align_err;
   logic          cmd_err;
   logic [3:0]    be;
   logic          cmd_fire;
   logic          rsp_fire;
   logic [31:0]   push_rdata;

   assign off       = nice_icb_cmd_addr - BASE_ADDR;
   assign idx       = off[AW+1:2];
   assign range_err = (nice_icb_cmd_addr < BASE_ADDR) || ((off >> (AW + 2)) != 32'd0);

   always_comb begin
      align_err = 1'b0;
      be        = 4'b0000;
      case (nice_icb_cmd_size)
         2'd0: be = 4'b0001 << nice_icb_cmd_addr[1:0];
         2'd1: begin
            align_err = nice_icb_cmd_addr[0];
            be        = nice_icb_cmd_addr[1] ? 4'b1100 : 4'b0011;
         end
         2'd2: begin
            align_err = (nice_icb_cmd_addr[1:0] != 2'b00);
            be        = 4'b1111;
         end
         default: align_err = 1'b1;
      endcase
   end

   assign cmd_err = align_err || range_err;

   // Gating with reset keeps the non-reset memory from being written while in reset.
   assign nice_icb_cmd_ready = nice_rst_n && (count != 2'd2);
   assign cmd_fire           = nice_icb_cmd_valid && nice_icb_cmd_ready;
   assign nice_icb_rsp_valid = (count != 2'd0);
   assign rsp_fire           = nice_icb_rsp_valid && nice_icb_rsp_ready;
   assign nice_icb_rsp_rdata = head_rdata;
   assign nice_icb_rsp_err   = head_err;

   assign push_rdata = (nice_icb_cmd_read && !cmd_err) ? mem[idx] : 32'h0;

   always_ff @(posedge nice_clk) begin
      if (cmd_fire && !nice_icb_cmd_read && !cmd_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= nice_icb_cmd_wdata[8*b +: 8];
         end
      end
   end

   // Two-entry shift FIFO: head is always the oldest response.
   always_ff @(posedge nice_clk or negedge nice_rst_n) begin
      if (!nice_rst_n) begin
         count      <= 2'd0;
         head_rdata <= 32'h0;
         head_err   <= 1'b0;
         tail_rdata <= 32'h0;
         tail_err   <= 1'b0;
      end else begin
         case ({cmd_fire, rsp_fire})
            2'b10: begin
               if (count == 2'd0) begin
                  head_rdata <= push_rdata;
                  head_err   <= cmd_err;
               end else begin
                  tail_rdata <= push_rdata;
                  tail_err   <= cmd_err;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_rdata <= tail_rdata;
               head_err   <= tail_err;
               count      <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  head_rdata <= tail_rdata;
                  head_err   <= tail_err;
                  tail_rdata <= push_rdata;
                  tail_err   <= cmd_err;
               end else begin
                  head_rdata <= push_rdata;
                  head_err   <= cmd_err;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nice_icb_mem_slave.sv
// Randomized self-checking bench for nice_icb_mem_slave against a queue/array
// reference model derived from the access rules.
module tb_nice_icb_mem_slave;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          AW   = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic        cmd_read = 1'b0;
   logic [31:0] cmd_wdata = '0;
   logic [1:0]  cmd_size = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mdl_mem [1 << AW];
   logic [32:0] mdl_q [$];

   always #5 clk = ~clk;

   nice_icb_mem_slave #(.BASE_ADDR(BASE), .AW(AW)) dut (
      .nice_clk           (clk),
      .nice_rst_n         (rst_n),
      .nice_icb_cmd_valid (cmd_valid),
      .nice_icb_cmd_ready (cmd_ready),
      .nice_icb_cmd_addr  (cmd_addr),
      .nice_icb_cmd_read  (cmd_read),
      .nice_icb_cmd_wdata (cmd_wdata),
      .nice_icb_cmd_size  (cmd_size),
      .nice_icb_rsp_valid (rsp_valid),
      .nice_icb_rsp_ready (rsp_ready),
      .nice_icb_rsp_rdata (rsp_rdata),
      .nice_icb_rsp_err   (rsp_err)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference behaviour of one accepted command; returns {err, rdata}.
   function automatic logic [32:0] model_cmd(input logic [31:0] addr, input logic rd,
                                             input logic [31:0] wd, input logic [1:0] sz);
      longint unsigned a = addr;
      int idx, lo, n;
      bit err;
      err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
            (a < BASE) || ((a - BASE) / 4 >= (longint'(1) << AW));
      if (err) return {1'b1, 32'h0};
      idx = int'((a - BASE) / 4);
      if (rd) return {1'b0, mdl_mem[idx]};
      n  = 1 << sz;
      lo = int'(a % 4);
      for (int b = lo; b < lo + n; b++) mdl_mem[idx][8*b +: 8] = wd[8*b +: 8];
      return {1'b0, 32'h0};
   endfunction

   task automatic step(input logic v, input logic [31:0] a, input logic rd,
                       input logic [31:0] wd, input logic [1:0] sz, input logic rr);
      logic acc, pop;
      logic [32:0] r;
      @(negedge clk);
      chk_eq("rsp_valid", 32'(rsp_valid), 32'(mdl_q.size() != 0));
      chk_eq("cmd_ready", 32'(cmd_ready), 32'(mdl_q.size() < 2));
      if (mdl_q.size() != 0) begin
         chk_eq("rsp_rdata", rsp_rdata, mdl_q[0][31:0]);
         chk_eq("rsp_err", 32'(rsp_err), 32'(mdl_q[0][32]));
      end
      cmd_valid = v; cmd_addr = a; cmd_read = rd; cmd_wdata = wd; cmd_size = sz;
      rsp_ready = rr;
      acc = v && (mdl_q.size() < 2);
      pop = (mdl_q.size() != 0) && rr;
      r   = '0;
      if (acc) r = model_cmd(a, rd, wd, sz);
      if (pop) void'(mdl_q.pop_front());
      if (acc) mdl_q.push_back(r);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      step(1'b1, a, 1'b0, d, sz, 1'b1);
   endtask

   task automatic rd(input logic [31:0] a);
      step(1'b1, a, 1'b1, $urandom, 2'd2, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, $urandom, 2'($urandom), 1'b1);
   endtask

   initial begin
      logic [31:0] a, d;
      logic [1:0]  sz;
      int          k;

      repeat (2) @(negedge clk);
      chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk_eq("rst_rdata", rsp_rdata, 32'h0);
      chk_eq("rst_err", 32'(rsp_err), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) wr(BASE + 32'(i * 4), $urandom, 2'd2);
      idle(2);

      wr(32'h10, 32'hDEAD_BEEF, 2'd2);
      rd(32'h10);
      idle(2);

      wr(32'h12, 32'h00AA_0000, 2'd0);
      wr(32'h10, 32'h0000_1234, 2'd1);
      rd(32'h10);
      idle(2);
      chk_eq("merge_model", mdl_mem[4], 32'hDEAA_1234);

      // Backpressure: third command only enters after the first pop.
      step(1'b1, 32'h10, 1'b1, 32'h0, 2'd2, 1'b0);
      step(1'b1, 32'h14, 1'b1, 32'h0, 2'd2, 1'b0);
      step(1'b1, 32'h18, 1'b1, 32'h0, 2'd2, 1'b0);
      step(1'b1, 32'h18, 1'b1, 32'h0, 2'd2, 1'b1);
      step(1'b1, 32'h18, 1'b1, 32'h0, 2'd2, 1'b1);
      idle(3);

      step(1'b1, 32'h11, 1'b1, 32'h0, 2'd2, 1'b1);
      step(1'b1, 32'h14, 1'b0, 32'hFFFF_FFFF, 2'd3, 1'b1);
      step(1'b1, 32'h1000, 1'b1, 32'h0, 2'd2, 1'b1);
      step(1'b1, 32'h1001, 1'b0, 32'h0, 2'd1, 1'b1);
      rd(32'h10);
      rd(32'h14);
      idle(2);

      for (int i = 0; i < 8; i++) begin
         wr(32'h20, $urandom, 2'd2);
         rd(32'h20);
      end
      idle(2);

      for (int i = 0; i < 600; i++) begin
         k  = int'($urandom % 16);
         sz = 2'($urandom % 3);
         a  = BASE + 32'(($urandom % 16) * 4) + ((32'($urandom % 4) >> sz) << sz);
         if (k == 0) sz = 2'd3;
         else if (k == 1) begin
            sz = 2'd2;
            a  = BASE + 32'(($urandom % 16) * 4) + 32'($urandom % 3 + 1);
         end else if (k == 2) a = BASE + 32'h1000 + 32'($urandom % 64) * 4;
         d = $urandom;
         step(($urandom % 4) != 0, a, $urandom % 2 == 0, d, sz, ($urandom % 3) != 0);
      end
      idle(3);

      // Reset with two responses pending; writes presented during reset must be ignored.
      step(1'b1, 32'h0C, 1'b1, 32'h0, 2'd2, 1'b0);
      step(1'b1, 32'h08, 1'b1, 32'h0, 2'd2, 1'b0);
      step(1'b0, 32'h0, 1'b1, 32'h0, 2'd2, 1'b0);
      chk_eq("pre_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk_eq("mid_rst_rdata", rsp_rdata, 32'h0);
      chk_eq("mid_rst_err", 32'(rsp_err), 32'd0);
      mdl_q.delete();
      cmd_valid = 1'b1; cmd_addr = 32'h0C; cmd_read = 1'b0;
      cmd_wdata = 32'h5555_5555; cmd_size = 2'd2; rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_eq("in_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      rd(32'h0C);
      rd(32'h08);
      rd(32'h10);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nice_icb_mem_slave.md
NICE_ICB_MEM_SLAVE -- requirements
Module: nice_icb_mem_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-002 SHALL have parameter AW, default 10, word-address width; memory holds 2^AW 32-bit words.
REQ-003 SHALL have port nice_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port nice_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port nice_icb_cmd_valid  input  1  command valid from initiator.
REQ-006 SHALL have port nice_icb_cmd_ready  output  1  command accepted when high with valid.
REQ-007 SHALL have port nice_icb_cmd_addr  input  32  byte address.
REQ-008 SHALL have port nice_icb_cmd_read  input  1  1 = read, 0 = write.
REQ-009 SHALL have port nice_icb_cmd_wdata  input  32  write data, lane-aligned to address.
REQ-010 SHALL have port nice_icb_cmd_size  input  2  0 byte, 1 halfword, 2 word, 3 illegal.
REQ-011 SHALL have port nice_icb_rsp_valid  output  1  response valid.
REQ-012 SHALL have port nice_icb_rsp_ready  input  1  initiator accepts response.
REQ-013 SHALL have port nice_icb_rsp_rdata  output  32  read data, full aligned word.
REQ-014 SHALL have port nice_icb_rsp_err  output  1  response error flag.

Function
REQ-015 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high (cmd handshake).
REQ-016 SHALL hold a 2-entry in-order response FIFO {rdata, err} and a count 0..2.
REQ-017 SHALL drive cmd_ready = (count < 2), with no same-cycle bypass when count is 2.
REQ-018 SHALL drive rsp_valid = (count != 0); rsp_rdata/rsp_err from the FIFO head, stable while rsp_valid high and rsp_ready low.
REQ-019 SHALL pop on rsp_valid and rsp_ready; push on cmd handshake; on simultaneous push and pop, count unchanged, order preserved.
REQ-020 SHALL give a response no earlier than the cycle after acceptance (minimum latency 1 cycle).
REQ-021 SHALL flag err when: size==3; address misaligned (size 1 with addr[0]!=0, size 2 with addr[1:0]!=0); or (addr-BASE_ADDR)>>2 >= 2^AW, or addr < BASE_ADDR.
REQ-022 SHALL on error commands leave memory unchanged and push rdata 32'h0, err 1.
REQ-023 SHALL on a legal read push the word at index (addr-BASE_ADDR)>>2, as held at the acceptance edge, with err 0.
REQ-024 SHALL on a legal write update memory at the acceptance edge using byte enables: size 0 -> lane addr[1:0]; size 1 -> lanes {addr[1],0} and {addr[1],1}; size 2 -> all lanes; little-endian; push rdata 32'h0, err 0.
REQ-025 SHALL make a write visible to any read accepted on a later edge, including back-to-back cycles.
REQ-026 SHALL ignore cmd_addr/cmd_read/cmd_wdata/cmd_size on cycles without cmd handshake.
REQ-027 SHALL keep the response FIFO order equal to command acceptance order for mixed reads, writes and errors.

Reset
REQ-028 SHALL on nice_rst_n low, asynchronously: count 0, rsp_valid 0, rsp_rdata 32'h0, rsp_err 0, cmd_ready 1 after release.
REQ-029 SHALL discard pending responses when reset is asserted mid-transfer; memory contents are not reset and not altered.
REQ-030 SHALL accept no command while nice_rst_n is low.

Verification
REQ-031 Word write 0x0000_0010 <= 0xDEAD_BEEF, then read 0x10 -> write rsp rdata 0, err 0; read rsp rdata 0xDEAD_BEEF, err 0, one cycle after acceptance.
REQ-032 After REQ-031, byte write addr 0x12 wdata 0x00AA_0000 size 0, then halfword write addr 0x10 wdata 0x0000_1234 size 1, read 0x10 -> 0xDEAA_1234.
REQ-033 rsp_ready held low, three back-to-back commands -> first two accepted, cmd_ready 0 with count 2; rsp_ready raised -> third accepted only on the edge after the first pop; responses returned in order.
REQ-034 Read addr 0x11 size 2, write size 3, read addr 0x1000 (AW=10) -> each err 1, rdata 0, memory unchanged on a later read-back.
REQ-035 Continuous cmd_valid and rsp_ready with alternating write/read to the same address -> one command per cycle, each read returns the value of the immediately preceding write.
REQ-036 Reset asserted with count 2 -> rsp_valid 0 immediately; after release cmd_ready 1, no stale response, earlier-written memory data still readable.
